// File: rtl/psum_acc_pkg.sv
// Shared types and saturating arithmetic for the psum line accumulator.
// The feature macro PSUM_ACC_RELU_EN itself is used in psum_acc_lane.sv.
package psum_acc_pkg;

    localparam int ACC_WIDTH_DEF = 16;
    localparam int SAT_W         = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Operands arrive sign-extended to SAT_W; the result is clamped to a signed w-bit range.
    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int unsigned             w
    );
        logic signed [SAT_W:0] sum;
        logic signed [SAT_W:0] hi;
        logic signed [SAT_W:0] lo;
        sum = (SAT_W+1)'(a) + (SAT_W+1)'(b);
        hi  = ((SAT_W+1)'(1) <<< (w - 1)) - (SAT_W+1)'(1);
        lo  = -hi - (SAT_W+1)'(1);
        if (sum > hi) begin
            return SAT_W'(hi);
        end else if (sum < lo) begin
            return SAT_W'(lo);
        end
        return SAT_W'(sum);
    endfunction

endpackage

// File: rtl/psum_line_accumulator_if.sv
// Psum input / accumulated-line output bundle of psum_line_accumulator.
interface psum_line_accumulator_if
    import psum_acc_pkg::*;
#(
    parameter int BIT_WIDTH  = 8,
    parameter int NUM_KERNEL = 4,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int MAX_LINE   = 64,
    parameter int MAX_PASS   = 16
);
    logic                                i_start;
    logic [$clog2(MAX_LINE+1)-1:0]       cfg_line_len;
    logic [$clog2(MAX_PASS+1)-1:0]       cfg_num_pass;
    logic [BIT_WIDTH*NUM_KERNEL-1:0]     i_psum;
    logic                                i_psum_val;
    logic [ACC_WIDTH*NUM_KERNEL-1:0]     o_data;
    logic                                o_data_val;
    logic [$clog2(MAX_LINE)-1:0]         o_data_pos;
    logic                                o_busy;
    logic                                o_done;
    logic                                o_err_drop;

    modport master (
        output i_start, cfg_line_len, cfg_num_pass, i_psum, i_psum_val,
        input  o_data, o_data_val, o_data_pos, o_busy, o_done, o_err_drop
    );

    modport slave (
        input  i_start, cfg_line_len, cfg_num_pass, i_psum, i_psum_val,
        output o_data, o_data_val, o_data_pos, o_busy, o_done, o_err_drop
    );

endinterface

// File: rtl/psum_acc_lane.sv
// One kernel lane: sign-extend, first-pass select, saturating add and optional ReLU.
// PSUM_ACC_RELU_EN clamps negative output values to zero; buffer write-back is never clamped.
module psum_acc_lane
    import psum_acc_pkg::*;
#(
    parameter int BIT_WIDTH = 8,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
    input  logic [BIT_WIDTH-1:0] psum,
    input  logic [ACC_WIDTH-1:0] acc_old,
    input  logic                 first_pass,
    output logic [ACC_WIDTH-1:0] wr_val,
    output logic [ACC_WIDTH-1:0] out_val
);
    logic signed [ACC_WIDTH-1:0] ext;
    logic signed [SAT_W-1:0]     sum;

    always_comb begin
        ext     = {{(ACC_WIDTH-BIT_WIDTH){psum[BIT_WIDTH-1]}}, psum};
        sum     = sat_add(SAT_W'(ext), SAT_W'($signed(acc_old)), ACC_WIDTH);
        wr_val  = first_pass ? ext : ACC_WIDTH'(sum);
        out_val = wr_val;
`ifdef PSUM_ACC_RELU_EN
        if (wr_val[ACC_WIDTH-1]) begin
            out_val = '0;
        end
`endif
    end

endmodule

// File: rtl/psum_line_accumulator.sv
// Multi-pass line accumulator: sums per-kernel psums per position, emits the final line.
// Build option PSUM_ACC_RELU_EN (see psum_acc_lane) zeroes negative final results.
module psum_line_accumulator
    import psum_acc_pkg::*;
#(
    parameter int BIT_WIDTH  = 8,
    parameter int NUM_KERNEL = 4,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int MAX_LINE   = 64,
    parameter int MAX_PASS   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    psum_line_accumulator_if.slave   bus
);
    localparam int LEN_W  = $clog2(MAX_LINE+1);
    localparam int PASS_W = $clog2(MAX_PASS+1);
    localparam int POS_W  = $clog2(MAX_LINE);

    state_t                                 state;
    state_t                                 state_nxt;
    logic [LEN_W-1:0]                       line_len;
    logic [PASS_W-1:0]                      num_pass;
    logic [POS_W-1:0]                       pos_cnt;
    logic [PASS_W-1:0]                      pass_cnt;
    logic [NUM_KERNEL-1:0][ACC_WIDTH-1:0]   line_buf [MAX_LINE];
    logic [NUM_KERNEL-1:0][ACC_WIDTH-1:0]   lane_wr;
    logic [NUM_KERNEL-1:0][ACC_WIDTH-1:0]   lane_out;
    logic                                   beat;
    logic                                   last_pos;
    logic                                   last_pass;
    logic                                   first_pass;

    always_comb begin
        beat       = (state == ST_RUN) && bus.i_psum_val;
        last_pos   = (LEN_W'(pos_cnt) == line_len - LEN_W'(1));
        last_pass  = (pass_cnt == num_pass - PASS_W'(1));
        first_pass = (pass_cnt == '0);
        bus.o_busy = (state == ST_RUN);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.i_start) state_nxt = ST_RUN;
            ST_RUN:  if (beat && last_pos && last_pass) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_len <= '0;
            num_pass <= '0;
            pos_cnt  <= '0;
            pass_cnt <= '0;
        end else if (state == ST_IDLE) begin
            if (bus.i_start) begin
                // A zero length or pass count runs as one.
                line_len <= (bus.cfg_line_len == '0) ? LEN_W'(1) : bus.cfg_line_len;
                num_pass <= (bus.cfg_num_pass == '0) ? PASS_W'(1) : bus.cfg_num_pass;
                pos_cnt  <= '0;
                pass_cnt <= '0;
            end
        end else if (beat) begin
            if (last_pos) begin
                pos_cnt  <= '0;
                pass_cnt <= last_pass ? '0 : pass_cnt + PASS_W'(1);
            end else begin
                pos_cnt  <= pos_cnt + POS_W'(1);
            end
        end
    end

    // Pass 0 overwrites every position, so the buffer carries no reset.
    always_ff @(posedge clk) begin
        if (beat && !last_pass) begin
            line_buf[pos_cnt] <= lane_wr;
        end
    end

    for (genvar k = 0; k < NUM_KERNEL; k++) begin : g_lane
        psum_acc_lane #(
            .BIT_WIDTH (BIT_WIDTH),
            .ACC_WIDTH (ACC_WIDTH)
        ) u_lane (
            .psum       (bus.i_psum[k*BIT_WIDTH +: BIT_WIDTH]),
            .acc_old    (line_buf[pos_cnt][k]),
            .first_pass (first_pass),
            .wr_val     (lane_wr[k]),
            .out_val    (lane_out[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.o_data     <= '0;
            bus.o_data_val <= 1'b0;
            bus.o_data_pos <= '0;
            bus.o_done     <= 1'b0;
            bus.o_err_drop <= 1'b0;
        end else begin
            bus.o_data_val <= beat && last_pass;
            bus.o_done     <= beat && last_pass && last_pos;
            if (beat && last_pass) begin
                bus.o_data     <= lane_out;
                bus.o_data_pos <= pos_cnt;
            end
            // A psum in the same cycle as a start still counts as dropped.
            if (state == ST_IDLE) begin
                if (bus.i_start)    bus.o_err_drop <= 1'b0;
                if (bus.i_psum_val) bus.o_err_drop <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_psum_line_accumulator.sv
// Randomized self-checking bench for psum_line_accumulator against a per-job arithmetic model.
module tb_psum_line_accumulator;
    localparam int BW = 8;
    localparam int NK = 4;
    localparam int AW = 16;
    localparam int ML = 64;
    localparam int MP = 300;
    localparam int LW = $clog2(ML+1);
    localparam int PW = $clog2(MP+1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    psum_line_accumulator_if #(
        .BIT_WIDTH(BW), .NUM_KERNEL(NK), .ACC_WIDTH(AW), .MAX_LINE(ML), .MAX_PASS(MP)
    ) bus ();

    psum_line_accumulator #(
        .BIT_WIDTH(BW), .NUM_KERNEL(NK), .ACC_WIDTH(AW), .MAX_LINE(ML), .MAX_PASS(MP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [AW*NK-1:0] data;
        int               pos;
        bit               done;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             cur;
    logic [AW*NK-1:0] log_data[$];
    int               log_pos[$];
    bit               log_done[$];
    int               checks   = 0;
    int               failures = 0;
    int               acc[ML][NK];
    int               m_len;
    int               m_np;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", name, got, want, $time);
        end
    endtask

    function automatic int clamp16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_data_val === 1'b1) begin
                log_data.push_back(bus.o_data);
                log_pos.push_back(int'(bus.o_data_pos));
                log_done.push_back(bus.o_done);
                if (exp_q.size() == 0) begin
                    chk("unexpected_val", 64'(bus.o_data_val), 64'(0));
                end else begin
                    cur = exp_q.pop_front();
                    chk("data", bus.o_data, cur.data);
                    chk("pos", 64'(bus.o_data_pos), 64'(cur.pos));
                    chk("done", 64'(bus.o_done), 64'(cur.done));
                end
            end else begin
                chk("done_without_val", 64'(bus.o_done), 64'(0));
            end
        end
    end

    task automatic start_job(input int len, input int np);
        bus.cfg_line_len = LW'(len);
        bus.cfg_num_pass = PW'(np);
        bus.i_start      = 1'b1;
        m_len = (len == 0) ? 1 : len;
        m_np  = (np == 0) ? 1 : np;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        chk("busy_after_start", 64'(bus.o_busy), 64'(1));
    endtask

    // Presents one beat and folds it into the model; final-pass results are queued.
    task automatic drive_beat(input logic [31:0] ps, input int p, input int x,
                              input int gap, input bit poke_start);
        logic [63:0] d;
        int v;
        int o;
        d = '0;
        bus.i_psum     = ps;
        bus.i_psum_val = 1'b1;
        if (poke_start) begin
            bus.i_start      = 1'b1;
            bus.cfg_line_len = LW'($urandom);
            bus.cfg_num_pass = PW'($urandom);
        end
        for (int k = 0; k < NK; k++) begin
            v = int'($signed(ps[k*BW +: BW]));
            acc[x][k] = (p == 0) ? v : clamp16(acc[x][k] + v);
            o = acc[x][k];
`ifdef PSUM_ACC_RELU_EN
            if (o < 0) o = 0;
`endif
            d[k*AW +: AW] = o[AW-1:0];
        end
        if (p == m_np - 1) exp_q.push_back('{data: d, pos: x, done: (x == m_len - 1)});
        @(posedge clk); #1;
        bus.i_psum_val = 1'b0;
        bus.i_start    = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    // mode 0: random psums, 1: fixed value, 2: every lane = position+1
    task automatic run_job(input int mode, input logic [31:0] fixed, input bit gaps);
        logic [31:0] ps;
        int gap;
        for (int p = 0; p < m_np; p++) begin
            for (int x = 0; x < m_len; x++) begin
                case (mode)
                    0:       ps = $urandom;
                    1:       ps = fixed;
                    default: ps = {4{8'(x + 1)}};
                endcase
                gap = (gaps && $urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
                drive_beat(ps, p, x, gap, gaps && ($urandom_range(0, 39) == 0));
            end
        end
    endtask

    task automatic finish_job();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain", 64'(exp_q.size()), 64'(0));
        chk("idle_after_job", 64'(bus.o_busy), 64'(0));
        @(posedge clk); #1;
    endtask

    task automatic clear_log();
        log_data.delete();
        log_pos.delete();
        log_done.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ps;
        bus.i_start      = 1'b0;
        bus.cfg_line_len = '0;
        bus.cfg_num_pass = '0;
        bus.i_psum       = '0;
        bus.i_psum_val   = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_val", 64'(bus.o_data_val), 64'(0));
        chk("rst_busy", 64'(bus.o_busy), 64'(0));
        chk("rst_done", 64'(bus.o_done), 64'(0));
        chk("rst_err", 64'(bus.o_err_drop), 64'(0));
        chk("rst_data", bus.o_data, 64'(0));
        chk("rst_pos", 64'(bus.o_data_pos), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Three passes of 1,2,3 -> 3,6,9
        clear_log();
        start_job(3, 3);
        run_job(2, '0, 1'b0);
        finish_job();
        chk("t1_count", 64'(log_data.size()), 64'(3));
        if (log_data.size() >= 3) begin
            chk("t1_pos0", log_data[0], 64'h0003_0003_0003_0003);
            chk("t1_pos1", log_data[1], 64'h0006_0006_0006_0006);
            chk("t1_pos2", log_data[2], 64'h0009_0009_0009_0009);
            chk("t1_pos2_idx", 64'(log_pos[2]), 64'(2));
            chk("t1_done2", 64'(log_done[2]), 64'(1));
            chk("t1_done0", 64'(log_done[0]), 64'(0));
        end

        // Single pass: sign extension and 1-cycle latency
        clear_log();
        start_job(2, 1);
        drive_beat({8'd7, 8'd0, 8'd0, 8'hFB}, 0, 0, 0, 1'b0);
        chk("t2_latency", 64'(bus.o_data_val), 64'(1));
        drive_beat($urandom, 0, 1, 0, 1'b0);
        finish_job();
        if (log_data.size() >= 1) chk("t2_ext", log_data[0], 64'h0007_0000_0000_FFFB);

        // 300 passes saturate both directions without wrapping
        clear_log();
        start_job(1, 300);
        for (int p = 0; p < 300; p++) drive_beat({8'h80, 8'd127, 8'h80, 8'd127}, p, 0, 0, 1'b0);
        finish_job();
`ifdef PSUM_ACC_RELU_EN
        if (log_data.size() >= 1) chk("t3_sat", log_data[0], 64'h0000_7FFF_0000_7FFF);
`else
        if (log_data.size() >= 1) chk("t3_sat", log_data[0], 64'h8000_7FFF_8000_7FFF);
`endif

        // Psum in IDLE is dropped and flagged; next start clears the flag
        bus.i_psum     = $urandom;
        bus.i_psum_val = 1'b1;
        @(posedge clk); #1;
        bus.i_psum_val = 1'b0;
        chk("t4_err_set", 64'(bus.o_err_drop), 64'(1));
        repeat (2) @(posedge clk);
        #1;
        chk("t4_err_sticky", 64'(bus.o_err_drop), 64'(1));
        start_job(4, 2);
        chk("t4_err_clr", 64'(bus.o_err_drop), 64'(0));
        run_job(0, '0, 1'b1);
        finish_job();

        // Reset mid-job, including a reset that lands on a final-pass beat
        start_job(3, 3);
        for (int i = 0; i < 4; i++) drive_beat($urandom, i / 3, i % 3, 0, 1'b0);
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        start_job(2, 1);
        bus.i_psum     = $urandom;
        bus.i_psum_val = 1'b1;
        rst            = 1'b1;
        @(posedge clk); #1;
        bus.i_psum_val = 1'b0;
        rst            = 1'b0;
        @(negedge clk);
        chk("t5_no_pending", 64'(bus.o_data_val), 64'(0));
        chk("t5_idle", 64'(bus.o_busy), 64'(0));
        @(posedge clk); #1;
        clear_log();
        start_job(3, 3);
        run_job(1, {4{8'd1}}, 1'b0);
        finish_job();
        chk("t5_count", 64'(log_data.size()), 64'(3));
        for (int i = 0; i < log_data.size(); i++) chk("t5_fresh", log_data[i], 64'h0003_0003_0003_0003);

        // -4 then +1
        clear_log();
        start_job(1, 2);
        drive_beat({4{8'hFC}}, 0, 0, 0, 1'b0);
        drive_beat({4{8'h01}}, 1, 0, 0, 1'b0);
        finish_job();
`ifdef PSUM_ACC_RELU_EN
        if (log_data.size() >= 1) chk("t6_relu", log_data[0], 64'h0000_0000_0000_0000);
`else
        if (log_data.size() >= 1) chk("t6_relu", log_data[0], 64'hFFFD_FFFD_FFFD_FFFD);
`endif

        // Random jobs with gaps and ignored restarts
        for (int j = 0; j < 25; j++) begin
            start_job($urandom_range(0, ML), $urandom_range(0, 6));
            run_job(0, '0, 1'b1);
            finish_job();
        end

        // Long random job with extreme psums to hit saturation randomly
        start_job($urandom_range(1, 3), $urandom_range(200, 300));
        for (int p = 0; p < m_np; p++) begin
            for (int x = 0; x < m_len; x++) begin
                for (int k = 0; k < NK; k++) ps[k*BW +: BW] = ($urandom_range(0, 1) == 1) ? 8'd127 : 8'h80;
                drive_beat(ps, p, x, 0, 1'b0);
            end
        end
        finish_job();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
